dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_lane_align.sv | 49 ++++
 rtl/dmem_responder.sv | 150 +++++++++++++++
 tb/tb_dmem_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_pkg : shared types, transfer-size codes and helpers for the   |
// |            data-memory responder.                                  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;

  function automatic logic is_legal_size(input logic [3:0] size);
    return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) || (size == SZ_D);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_lane_align : byte-enable generation, store lane shift and     |
// |                   load extract/zero-extend for one 64-bit word.    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [3:0]  i_size,
  input  logic [2:0]  i_offset,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rword,
  output logic [7:0]  o_byte_en,
  output logic [63:0] o_wdata_lane,
  output logic [63:0] o_rdata
);

  logic [7:0]  w_size_mask;
  logic [63:0] w_bit_mask;
  logic [5:0]  w_shamt;

  always_comb begin
    w_size_mask = 8'h00;
    case (i_size)
      SZ_B:    w_size_mask = 8'h01;
      SZ_H:    w_size_mask = 8'h03;
      SZ_W:    w_size_mask = 8'h0F;
      SZ_D:    w_size_mask = 8'hFF;
      default: w_size_mask = 8'h00;
    endcase
  end

  assign w_shamt      = {i_offset, 3'b000};
  assign o_byte_en    = w_size_mask << i_offset;
  assign o_wdata_lane = i_wdata << w_shamt;

  // Load mask is sized by the transfer, applied after shifting the word down
  generate
    for (genvar k = 0; k < 8; k++) begin : g_lane
      assign w_bit_mask[8*k +: 8] = {8{w_size_mask[k]}};
    end
  endgenerate

  assign o_rdata = (i_rword >> w_shamt) & w_bit_mask;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_responder : fixed-latency data-memory responder with a        |
// |                  valid/ready request and response handshake.       |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [3:0]  req_size,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int          c_AW       = $clog2(DEPTH_BYTES);
  localparam int          c_WORDS    = DEPTH_BYTES / 8;
  localparam logic [3:0]  c_LOAD_CNT = 4'(LATENCY - 1);
  localparam logic [64:0] c_DEPTH    = 65'(DEPTH_BYTES);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_write;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [3:0]  r_size;
  logic [63:0] r_rdata;
  logic        r_error;
  logic [63:0] r_mem [c_WORDS];

  logic        w_accept, w_commit;
  logic        w_cur_write;
  logic [63:0] w_cur_addr, w_cur_wdata;
  logic [3:0]  w_cur_size;
  logic        w_illegal, w_misalign, w_range, w_err;
  logic [c_AW-4:0] w_idx;
  logic [7:0]  w_byte_en;
  logic [63:0] w_wdata_lane, w_lane_rdata;

  assign req_ready = (r_state == IDLE) && reset;
  assign w_accept  = req_valid && req_ready;
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_error = r_error;

  // With LATENCY 1 the commit happens on the accept edge, so take the request straight from the ports
  assign w_cur_write = (r_state == IDLE) ? req_write : r_write;
  assign w_cur_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_cur_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_cur_size  = (r_state == IDLE) ? req_size  : r_size;

  assign w_illegal  = !is_legal_size(w_cur_size);
  assign w_misalign = |(w_cur_addr[2:0] & (w_cur_size[2:0] - 3'd1));
  assign w_range    = (({1'b0, w_cur_addr} + {61'd0, w_cur_size}) > c_DEPTH);
  assign w_err      = w_illegal || w_misalign || w_range;
  assign w_idx      = w_cur_addr[c_AW-1:3];

  assign w_commit = ((r_state == IDLE) && w_accept && (LATENCY == 1)) ||
                    ((r_state == WAIT) && (r_cnt == 4'd1));

  dmem_lane_align u_lane_align (
    .i_size       (w_cur_size),
    .i_offset     (w_cur_addr[2:0]),
    .i_wdata      (w_cur_wdata),
    .i_rword      (r_mem[w_idx]),
    .o_byte_en    (w_byte_en),
    .o_wdata_lane (w_wdata_lane),
    .o_rdata      (w_lane_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = c_LOAD_CNT;
          end
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= 64'd0;
      r_wdata <= 64'd0;
      r_size  <= 4'd0;
      r_rdata <= 64'd0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_size  <= req_size;
      end
      if (w_commit) begin
        r_error <= w_err;
        r_rdata <= (w_err || w_cur_write) ? 64'd0 : w_lane_rdata;
      end else if ((r_state == RESP) && rsp_ready) begin
        r_error <= 1'b0;
        r_rdata <= 64'd0;
      end
    end
  end

  // Storage is not reset; an abandoned store never reaches the commit edge
  always_ff @(posedge clk) begin
    if (w_commit && w_cur_write && !w_err) begin
      for (int k = 0; k < 8; k++) begin
        if (w_byte_en[k]) r_mem[w_idx][8*k +: 8] <= w_wdata_lane[8*k +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dmem_responder : randomized bench with a byte-array model of    |
// |                     the responder and directed corner cases.       |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic [3:0]  req_size = 4'd0;
  logic        req_ready, rsp_valid, rsp_error;
  logic [63:0] rsp_rdata;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0]  mm [DEPTH];
  bit          busy = 1'b0;
  int          age = 0;
  logic [63:0] exp_rdata = 64'd0;
  bit          exp_err = 1'b0;
  logic [63:0] got_rdata = 64'd0;
  logic        got_err = 1'b0;

  dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_size  (req_size),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Byte-addressed reference: whole transaction evaluated at once
  function automatic void model(input bit w, input logic [63:0] a, input logic [63:0] wd,
                                input logic [3:0] sz, output logic [63:0] rd, output bit er);
    rd = 64'd0;
    er = 1'b0;
    if (!(sz == 4'd1 || sz == 4'd2 || sz == 4'd4 || sz == 4'd8)) er = 1'b1;
    else if ((a % 64'(sz)) != 64'd0) er = 1'b1;
    else if (a >= 64'(DEPTH) || a + 64'(sz) > 64'(DEPTH)) er = 1'b1;
    if (!er) begin
      for (int k = 0; k < int'(sz); k++) begin
        if (w) mm[int'(a) + k] = wd[8*k +: 8];
        else   rd[8*k +: 8] = mm[int'(a) + k];
      end
    end
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_error", rsp_error, 0);
    end else if (busy) begin
      chk("busy_req_ready", req_ready, 0);
      if (age < LAT) begin
        chk("rsp_valid_early", rsp_valid, 0);
      end else begin
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_error", rsp_error, 64'(exp_err));
      end
    end else begin
      chk("idle_req_ready", req_ready, 1);
      chk("idle_rsp_valid", rsp_valid, 0);
    end
  end

  task automatic scramble();
    req_valid = 1'($urandom);
    req_write = 1'($urandom);
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    req_size  = 4'($urandom);
  endtask

  // Entered just after a posedge with the DUT idle; returns just after the handshake edge
  task automatic txn(input bit w, input logic [63:0] a, input logic [63:0] wd,
                     input logic [3:0] sz, input int hold);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_size = sz;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    model(w, a, wd, sz, exp_rdata, exp_err);
    busy = 1'b1;
    age  = 1;
    scramble();
    while (age < LAT + hold) begin
      @(posedge clk); #1;
      age++;
      scramble();
    end
    got_rdata = rsp_rdata;
    got_err   = rsp_error;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    busy      = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic txn_abort(input bit w, input logic [63:0] a, input logic [63:0] wd,
                           input logic [3:0] sz, input int at_age);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_size = sz;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    if (!w) model(w, a, wd, sz, exp_rdata, exp_err);
    else begin exp_rdata = 64'd0; exp_err = 1'b0; end
    busy = 1'b1;
    age  = 1;
    req_valid = 1'b0;
    while (age < at_age) begin
      @(posedge clk); #1;
      age++;
    end
    #1 reset = 1'b0;
    busy = 1'b0;
    #1;
    chk("async_rsp_valid", rsp_valid, 0);
    chk("async_rsp_rdata", rsp_rdata, 0);
    chk("async_rsp_error", rsp_error, 0);
    chk("async_req_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  sz_tab [11];
    logic [3:0]  sz;
    logic [63:0] a;
    sz_tab = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd0, 4'd5};

    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < DEPTH / 8; i++) txn(1'b1, 64'(i * 8), {$urandom, $urandom}, 4'd8, 0);

    txn(1'b1, 64'h10, 64'h1122334455667788, 4'd8, 0);
    chk("lit_st8_err", 64'(got_err), 0);
    txn(1'b0, 64'h10, 64'd0, 4'd8, 0);
    chk("lit_ld8", got_rdata, 64'h1122334455667788);
    txn(1'b1, 64'h13, 64'h00000000000000AB, 4'd1, 0);
    txn(1'b0, 64'h10, 64'd0, 4'd4, 0);
    chk("lit_ld4_b13", got_rdata, 64'h00000000AB667788);
    txn(1'b1, 64'h10, 64'h1122334455667788, 4'd8, 0);
    txn(1'b1, 64'h12, 64'hFFFFFFFFFFFFFFAB, 4'd1, 0);
    txn(1'b0, 64'h10, 64'd0, 4'd4, 0);
    chk("lit_ld4_b12", got_rdata, 64'h0000000055AB7788);

    txn(1'b0, 64'h12, 64'd0, 4'd4, 0);
    chk("lit_misalign_err", 64'(got_err), 1);
    chk("lit_misalign_rdata", got_rdata, 0);
    txn(1'b0, 64'h10, 64'd0, 4'd8, 0);
    chk("lit_ld8_after_err", got_rdata, 64'h1122334455AB7788);

    txn(1'b1, 64'(DEPTH - 8), 64'h0123456789ABCDEF, 4'd8, 0);
    chk("lit_top_store_err", 64'(got_err), 0);
    txn(1'b1, 64'(DEPTH - 4), 64'hDEADBEEFDEADBEEF, 4'd8, 0);
    chk("lit_range_err", 64'(got_err), 1);
    txn(1'b0, 64'(DEPTH - 8), 64'd0, 4'd8, 0);
    chk("lit_range_unchanged", got_rdata, 64'h0123456789ABCDEF);
    txn(1'b1, 64'h18, 64'h55, 4'd3, 0);
    chk("lit_size3_err", 64'(got_err), 1);
    txn(1'b0, 64'h1_0000_0010, 64'd0, 4'd8, 0);
    chk("lit_highaddr_err", 64'(got_err), 1);

    txn(1'b0, 64'h10, 64'd0, 4'd8, 5);
    chk("lit_hold_rdata", got_rdata, 64'h1122334455AB7788);
    chk("lit_ready_after_hs", 64'(req_ready), 1);

    txn(1'b1, 64'h20, 64'hCAFEBABEDEADBEEF, 4'd8, 0);
    txn_abort(1'b1, 64'h20, 64'hFF, 4'd1, 1);
    txn(1'b0, 64'h20, 64'd0, 4'd1, 0);
    chk("lit_abort_unchanged", got_rdata, 64'h00000000000000EF);
    txn_abort(1'b0, 64'h10, 64'd0, 4'd8, 2);

    for (int i = 0; i < 300; i++) begin
      sz = sz_tab[$urandom_range(0, 10)];
      case ($urandom_range(0, 9))
        7:       a = 64'($urandom_range(0, DEPTH - 1));
        8:       a = 64'(DEPTH - int'($urandom_range(1, 8)));
        9:       a = {$urandom, $urandom};
        default: a = 64'($urandom_range(0, DEPTH - 1)) & ~(64'(sz) - 64'd1);
      endcase
      txn(1'($urandom), a, {$urandom, $urandom}, sz, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
